eq2_bist: RTL and testbench
===========================

# eq2_bist

Built-in self-test sequencer for the 2-bit equality comparator (`eq2` family). On a `start_i` pulse it drives all 16 `{a,b}` input combinations into the comparator under test, then samples `aeqb` and checks it against an internally computed expected value. It counts mismatches and reports pass/fail through a one-cycle done handshake. It is the hardware counterpart to the file-driven simulation stimulus/logging bench, and is intended for on-board checking of comparator variants.

## Interface
- `SETTLE`, default 2: cycles each vector is held before its response is sampled; legal range 1–15.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `start_i` in 1: request a test run. Sampled only in IDLE.
- `dut_a_o` out 2: comparator operand a, registered.
- `dut_b_o` out 2: comparator operand b, registered.
- `dut_aeqb_i` in 1: comparator response; combinational from `dut_a_o`/`dut_b_o`.
- `busy_o` out 1: high while a run is in progress (APPLY/SAMPLE).
- `done_o` out 1: one-cycle pulse at the end of a run.
- `pass_o` out 1: 1 when the last completed run had zero errors; held until the next start.
- `err_cnt_o` out 5: mismatch count for the current or last run, range 0–16.
- `fail_valid_o` out 1: first-failure record is valid. Present only with the macro; see Configuration.
- `fail_idx_o` out 4: vector index of the first failure. Present only with the macro.
- `fail_resp_o` out 1: observed `aeqb` at the first failure. Present only with the macro.

## Operation
- Vector index `idx` is 4 bits, 0..15. Vector mapping: `dut_a_o = idx[3:2]`, `dut_b_o = idx[1:0]`. Expected response: `exp = (idx[3:2] == idx[1:0])`, true for idx 0, 5, 10 and 15.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
  - IDLE: `dut_a_o`/`dut_b_o` = 0. If `start_i`=1, go to APPLY. On the same edge: `idx`=0, `err_cnt_o`=0, `pass_o`=0, settle counter=0, and the first-failure record is cleared.
  - APPLY: drive vector `idx`. Increment the settle counter. When the counter reaches `SETTLE`−1, go to SAMPLE.
  - SAMPLE: compare `dut_aeqb_i` against `exp`. On a mismatch, increment `err_cnt_o`; no saturation is needed because the maximum is 16. If `idx`=15, go to DONE; otherwise increment `idx`, clear the settle counter, and go to APPLY.
  - DONE: `done_o`=1 and `pass_o` = (`err_cnt_o`==0). Go to IDLE unconditionally.
- `start_i` asserted outside IDLE is ignored. It is not queued.
- `err_cnt_o` is not cleared at DONE. It holds until the next accepted start.
- Reset values (asynchronous, `reset_n`=0): state=IDLE, `idx`=0, `dut_a_o`=0, `dut_b_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `err_cnt_o`=0, `fail_valid_o`=0, `fail_idx_o`=0, `fail_resp_o`=0.
- Reset mid-run aborts the run: no done pulse, and all outputs take their reset values.

## Timing
- Edge E0 samples `start_i`=1 in IDLE. `busy_o` is high from E0 until the edge that enters DONE.
- Each vector occupies `SETTLE` APPLY cycles plus 1 SAMPLE cycle. The response is sampled `SETTLE` cycles after the vector changes.
- A run is 16×(`SETTLE`+1) busy cycles. With the default `SETTLE`=2 that is 48 cycles. `done_o` is high for the single cycle after the last SAMPLE.
- `pass_o` and the final `err_cnt_o` are valid in the `done_o` cycle and remain valid afterwards.
- A new start is accepted at the earliest on the edge after DONE, when the block is in IDLE.
- `dut_aeqb_i` must settle within `SETTLE` cycles. It is not synchronized.

## Configuration
- Macro: `EQ2_BIST_CAPTURE_EN`.
- Defined:
  - On the first mismatch of a run, latch `fail_idx_o`=`idx` and `fail_resp_o`=`dut_aeqb_i`, and set `fail_valid_o`=1.
  - Later mismatches do not overwrite the record.
  - The record is cleared on an accepted start and on reset.
- Undefined: the three ports still exist but are tied to 0, with no capture logic.

## Test plan
- Ideal comparator (`aeqb` = (a==b)), `SETTLE`=2, start pulse -> `done_o` pulses 48 cycles after the start edge. Expected: `err_cnt_o`=0, `pass_o`=1, `fail_valid_o`=0.
- Comparator stuck at 0 -> `err_cnt_o`=4 and `pass_o`=0. With capture: `fail_idx_o`=0, `fail_resp_o`=0.
- Comparator stuck at 1 -> `err_cnt_o`=12. With capture: `fail_idx_o`=1, `fail_resp_o`=1.
- Inverted comparator (`aeqb` = ~(a==b)) -> `err_cnt_o`=16, `pass_o`=0. With capture: `fail_idx_o`=0.
- `start_i` re-pulsed at busy cycle 10 -> ignored; exactly one `done_o` at cycle 48. Then start again with an ideal comparator -> `err_cnt_o` clears to 0 and `pass_o` drops to 0 until the new done.
- `reset_n` low at busy cycle 20 -> all outputs at reset values immediately, with no `done_o`. A subsequent start runs a full 48-cycle test.

Source files
------------

// File: rtl/eq2_bist_if.sv
// Handshake and comparator-stimulus bundle for the eq2 BIST sequencer.
// The master modport is the requester/comparator side; the slave modport is the sequencer side.
interface eq2_bist_if;
  logic       start_i;
  logic [1:0] dut_a_o;
  logic [1:0] dut_b_o;
  logic       dut_aeqb_i;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [4:0] err_cnt_o;
  logic       fail_valid_o;
  logic [3:0] fail_idx_o;
  logic       fail_resp_o;

  modport master (
    output start_i, dut_aeqb_i,
    input  dut_a_o, dut_b_o, busy_o, done_o, pass_o, err_cnt_o,
           fail_valid_o, fail_idx_o, fail_resp_o
  );

  modport slave (
    input  start_i, dut_aeqb_i,
    output dut_a_o, dut_b_o, busy_o, done_o, pass_o, err_cnt_o,
           fail_valid_o, fail_idx_o, fail_resp_o
  );
endinterface

// File: rtl/eq2_bist.sv
// BIST sequencer: walks all 16 {a,b} vectors through a 2-bit equality comparator and counts mismatches.
// Define EQ2_BIST_CAPTURE_EN to record the first failing vector and its response.
module eq2_bist #(
  parameter int unsigned SETTLE = 2
) (
  input logic       clk,
  input logic       reset_n,
  eq2_bist_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic [3:0] settle_reg, settle_next;
  logic [4:0] err_reg, err_next;
  logic       pass_reg, pass_next;
  logic [1:0] a_reg, a_next;
  logic [1:0] b_reg, b_next;
  logic       mismatch;
  logic       run_next;

  assign mismatch = bus.dut_aeqb_i != (idx_reg[3:2] == idx_reg[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      settle_reg <= '0;
      err_reg    <= '0;
      pass_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      settle_reg <= settle_next;
      err_reg    <= err_next;
      pass_reg   <= pass_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    settle_next = settle_reg;
    err_next    = err_reg;
    pass_next   = pass_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          state_next  = APPLY;
          idx_next    = '0;
          settle_next = '0;
          err_next    = '0;
          pass_next   = 1'b0;
        end
      end
      APPLY: begin
        // The vector is held for SETTLE cycles before its one SAMPLE cycle.
        if (settle_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
        end else begin
          settle_next = settle_reg + 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_next = err_reg + 5'd1;
        end
        if (idx_reg == 4'd15) begin
          state_next = DONE;
          pass_next  = (err_next == 5'd0);
        end else begin
          state_next  = APPLY;
          idx_next    = idx_reg + 4'd1;
          settle_next = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Operands follow the next index so they change on the same edge as the vector step.
    run_next = (state_next == APPLY) || (state_next == SAMPLE);
    a_next   = run_next ? idx_next[3:2] : 2'b00;
    b_next   = run_next ? idx_next[1:0] : 2'b00;
  end

  assign bus.dut_a_o   = a_reg;
  assign bus.dut_b_o   = b_reg;
  assign bus.busy_o    = (state_reg == APPLY) || (state_reg == SAMPLE);
  assign bus.done_o    = (state_reg == DONE);
  assign bus.pass_o    = pass_reg;
  assign bus.err_cnt_o = err_reg;

`ifdef EQ2_BIST_CAPTURE_EN
  logic       fail_valid_reg;
  logic [3:0] fail_idx_reg;
  logic       fail_resp_reg;
  logic       clear_fail;
  logic       capture;

  assign clear_fail = (state_reg == IDLE) && bus.start_i;
  assign capture    = (state_reg == SAMPLE) && mismatch && !fail_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_valid_reg <= 1'b0;
      fail_idx_reg   <= '0;
      fail_resp_reg  <= 1'b0;
    end else if (clear_fail) begin
      fail_valid_reg <= 1'b0;
      fail_idx_reg   <= '0;
      fail_resp_reg  <= 1'b0;
    end else if (capture) begin
      fail_valid_reg <= 1'b1;
      fail_idx_reg   <= idx_reg;
      fail_resp_reg  <= bus.dut_aeqb_i;
    end
  end

  assign bus.fail_valid_o = fail_valid_reg;
  assign bus.fail_idx_o   = fail_idx_reg;
  assign bus.fail_resp_o  = fail_resp_reg;
`else
  assign bus.fail_valid_o = 1'b0;
  assign bus.fail_idx_o   = 4'd0;
  assign bus.fail_resp_o  = 1'b0;
`endif

endmodule

// File: tb/tb_eq2_bist.sv
// Bench for eq2_bist: a behavioural comparator with selectable faults, and a vector-level reference model
// that predicts error count, pass and first-failure record for each run.
module tb_eq2_bist;

  localparam int M_IDEAL  = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;
  localparam int M_INVERT = 3;
  localparam int M_MASK   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          mode = M_IDEAL;
  logic [15:0] mask = '0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  eq2_bist_if bus ();

  eq2_bist #(.SETTLE(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Comparator under test: the ideal function optionally corrupted by the selected fault.
  function automatic logic resp_of(input int m, input logic [15:0] mk, input int i);
    logic eq;
    eq = ((i / 4) == (i % 4));
    case (m)
      M_STUCK0: return 1'b0;
      M_STUCK1: return 1'b1;
      M_INVERT: return !eq;
      M_MASK:   return eq ^ mk[i];
      default:  return eq;
    endcase
  endfunction

  assign bus.dut_aeqb_i = resp_of(mode, mask, int'({bus.dut_a_o, bus.dut_b_o}));

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
    check({tag, "_done"}, int'(bus.done_o), 0);
    check({tag, "_pass"}, int'(bus.pass_o), 0);
    check({tag, "_err"}, int'(bus.err_cnt_o), 0);
    check({tag, "_a"}, int'(bus.dut_a_o), 0);
    check({tag, "_b"}, int'(bus.dut_b_o), 0);
    check({tag, "_fvalid"}, int'(bus.fail_valid_o), 0);
    check({tag, "_fidx"}, int'(bus.fail_idx_o), 0);
    check({tag, "_fresp"}, int'(bus.fail_resp_o), 0);
  endtask

  task automatic run(input string name, input int m, input logic [15:0] mk,
                     input int repulse_at, input int reset_at);
    int   exp_err;
    int   first_idx;
    logic first_resp;
    int   n;
    bit   got_done;
    int   extra_done;

    exp_err    = 0;
    first_idx  = -1;
    first_resp = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic r;
      r = resp_of(m, mk, i);
      if (r != ((i / 4) == (i % 4))) begin
        exp_err++;
        if (first_idx < 0) begin
          first_idx  = i;
          first_resp = r;
        end
      end
    end
    mode = m;
    mask = mk;

    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    check({name, "_busy_at_start"}, int'(bus.busy_o), 1);
    check({name, "_err_cleared"}, int'(bus.err_cnt_o), 0);
    check({name, "_pass_cleared"}, int'(bus.pass_o), 0);
    check({name, "_fvalid_cleared"}, int'(bus.fail_valid_o), 0);

    n = 0;
    got_done = 1'b0;
    while (n < 200 && !got_done) begin
      @(posedge clk);
      n++;
      #1;
      bus.start_i = (n == repulse_at);
      if (n == reset_at) begin
        bus.start_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs({name, "_abort"});
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          check({name, "_abort_no_done"}, int'(bus.done_o), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      got_done = bus.done_o;
      if (!got_done && (n % 5 == 0)) begin
        check({name, "_busy_mid"}, int'(bus.busy_o), 1);
        check({name, "_vec_a"}, int'(bus.dut_a_o), (n / 3) / 4);
        check({name, "_vec_b"}, int'(bus.dut_b_o), (n / 3) % 4);
      end
    end
    bus.start_i = 1'b0;

    check({name, "_done_seen"}, int'(got_done), 1);
    check({name, "_done_latency"}, n, 48);
    check({name, "_busy_in_done"}, int'(bus.busy_o), 0);
    check({name, "_err"}, int'(bus.err_cnt_o), exp_err);
    check({name, "_pass"}, int'(bus.pass_o), int'(exp_err == 0));
`ifdef EQ2_BIST_CAPTURE_EN
    check({name, "_fvalid"}, int'(bus.fail_valid_o), int'(exp_err > 0));
    if (exp_err > 0) begin
      check({name, "_fidx"}, int'(bus.fail_idx_o), first_idx);
      check({name, "_fresp"}, int'(bus.fail_resp_o), int'(first_resp));
    end
`else
    check({name, "_fvalid_tied"}, int'(bus.fail_valid_o), 0);
    check({name, "_fidx_tied"}, int'(bus.fail_idx_o), 0);
    check({name, "_fresp_tied"}, int'(bus.fail_resp_o), 0);
`endif

    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, int'(bus.done_o), 0);
    check({name, "_err_held"}, int'(bus.err_cnt_o), exp_err);
    check({name, "_pass_held"}, int'(bus.pass_o), int'(exp_err == 0));
    check({name, "_idle_a"}, int'(bus.dut_a_o), 0);

    if (repulse_at > 0) begin
      extra_done = 0;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk);
        #1;
        if (bus.done_o) extra_done++;
      end
      check({name, "_no_queued_run"}, extra_done, 0);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_start_busy", int'(bus.busy_o), 0);

    run("ideal", M_IDEAL, 16'h0000, 0, 0);
    run("stuck0_repulse", M_STUCK0, 16'h0000, 10, 0);
    run("ideal_after", M_IDEAL, 16'h0000, 0, 0);
    run("stuck1", M_STUCK1, 16'h0000, 0, 0);
    run("invert", M_INVERT, 16'h0000, 0, 0);
    run("abort", M_IDEAL, 16'h0000, 0, 20);
    run("after_abort", M_IDEAL, 16'h0000, 0, 0);
    for (int r = 0; r < 5; r++) begin
      logic [15:0] rm;
      rm = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run($sformatf("rand%0d", r), M_MASK, rm, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
